pipeline_ctrl: RTL

- Central hazard/stall scheduler for the 5-stage MIPS pipeline.
- Drives the stall, flush and PC-write controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves load-use hazards, taken-branch flushes, instruction-memory wait states and a multi-cycle mult/div unit that occupies EX for MD_LAT cycles.
- Sits beside the datapath; consumes decoded fields from ID/EX and a ready flag from instruction memory.

---
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: load-use, branch flush, I-mem wait, mult/div hold.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int MD_LAT = 4,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             EX_MulDiv,
  input  logic             IM_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
`ifdef PIPE_PERF_CNT_EN
  output logic             MD_Busy,
  output logic [15:0]      Stall_Cycles,
  output logic [15:0]      Flush_Count
`else
  output logic             MD_Busy
`endif
);

  localparam int CNT_W = $clog2(MD_LAT) + 1;
  localparam bit MULTI = (MD_LAT > 1);
  // First MDWAIT cycle loads MD_LAT-2 so that the hold spans MD_LAT-1 cycles in total.
  localparam logic [CNT_W-1:0] CNT_LOAD = MULTI ? CNT_W'(MD_LAT - 2) : '0;

  typedef enum logic {RUN, MDWAIT} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_next;
  logic             freeze;
  logic             rs_hit;
  logic             rt_hit;
  logic             load_use;

  always_comb begin
    rs_hit   = ID_UsesRs && (ID_Rs == EX_Rt);
    rt_hit   = ID_UsesRt && (ID_Rt == EX_Rt);
    load_use = EX_MemRead && (EX_Rt != '0) && (rs_hit || rt_hit);
    freeze   = ((state == RUN) && EX_MulDiv && MULTI) ||
               ((state == MDWAIT) && (md_cnt != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // The MDWAIT exit cycle ignores EX_MulDiv so the finished mult/div can leave EX.
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    case (state)
      RUN: begin
        if (EX_MulDiv && MULTI) begin
          state_next  = MDWAIT;
          md_cnt_next = CNT_LOAD;
        end
      end
      MDWAIT: begin
        if (md_cnt != '0) begin
          md_cnt_next = md_cnt - CNT_W'(1);
        end else begin
          state_next  = RUN;
        end
      end
      default: begin
        state_next  = RUN;
        md_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MD_Busy      = (state == MDWAIT);
    if (rst) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      MD_Busy      = 1'b0;
    end else if (freeze) begin
      IF_ID_Stall  = 1'b1;
      ID_EX_Stall  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      PC_Write     = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (load_use) begin
      IF_ID_Stall  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (!IM_Ready) begin
      IF_ID_Flush  = 1'b1;
    end else begin
      PC_Write     = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic branch_flush;

  assign branch_flush = EX_BranchTaken && !freeze;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Stall_Cycles <= '0;
      Flush_Count  <= '0;
    end else begin
      if (IF_ID_Stall && (Stall_Cycles != 16'hFFFF)) begin
        Stall_Cycles <= Stall_Cycles + 16'd1;
      end
      if (branch_flush && (Flush_Count != 16'hFFFF)) begin
        Flush_Count <= Flush_Count + 16'd1;
      end
    end
  end
`endif

endmodule
